// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
// Definitions shared by the SPI transaction sequencer and its command FIFO:
//   - seq_state_e : sequencer states (IDLE / WAIT / CAPT / RESP)
//   - ST_*        : bit positions inside the 6-bit master status word
//   - DIV_*       : SCK divider codes understood by the master
//   - pack_status : assembles a status word from its fields
// -----------------------------------------------------------------------------
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        CAPT = 2'd2,
        RESP = 2'd3
    } seq_state_e;

    // Status word layout: [5] enable, [4:2] divider, [1] first-bit order, [0] op.
    localparam int ST_OP     = 0;
    localparam int ST_FBO    = 1;
    localparam int ST_DIV_LO = 2;
    localparam int ST_DIV_HI = 4;
    localparam int ST_EN     = 5;

    localparam logic [2:0] DIV_1  = 3'b000;
    localparam logic [2:0] DIV_2  = 3'b001;
    localparam logic [2:0] DIV_4  = 3'b010;
    localparam logic [2:0] DIV_8  = 3'b011;
    localparam logic [2:0] DIV_16 = 3'b100;

    function automatic logic [5:0] pack_status(input logic       en,
                                               input logic [2:0] div,
                                               input logic       fbo,
                                               input logic       op);
        return {en, div, fbo, op};
    endfunction

endpackage

// File: rtl/spi_seq_fifo.sv
// -----------------------------------------------------------------------------
// spi_seq_fifo
// Synchronous command FIFO, DATA_WIDTH x FIFO_DEPTH. Pointers carry one extra
// wrap bit so full and empty are distinguished without a separate counter.
// Read data is the head entry, presented combinationally (show-ahead).
// Ports:
//   clk_i, rst_i    clock, asynchronous active-high reset (empties the FIFO)
//   push_i          write wr_data_i (ignored when full)
//   wr_data_i       entry to write
//   pop_i           discard head entry (ignored when empty)
//   rd_data_o       head entry
//   full_o, empty_o occupancy flags
// -----------------------------------------------------------------------------
module spi_seq_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  pop_i,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    output logic                  full_o,
    output logic                  empty_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [AW:0]           wr_ptr_q;
    logic [AW:0]           rd_ptr_q;
    logic                  do_push;
    logic                  do_pop;

    assign empty_o   = (wr_ptr_q == rd_ptr_q);
    // Same slot, opposite lap: the writer is a full lap ahead.
    assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_push   = push_i & ~full_o;
    assign do_pop    = pop_i & ~empty_o;
    assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
        end
    end

    // Storage needs no reset: an empty FIFO never exposes its contents.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
    end

endmodule

// File: rtl/spi_perifericos_seq.sv
// -----------------------------------------------------------------------------
// spi_perifericos_seq
// Transaction sequencer in front of the SPI peripheral master. Host bytes are
// queued in a command FIFO; each byte launches one master transaction through
// the master's status/data inputs. The op bit is held until the master's done
// pulse, the received word is captured and returned over a valid/ready port.
//
// Handshakes: a transfer happens on a clock edge where valid and ready are both
// high; a valid, once raised, holds its payload stable until that edge.
//
// Ports:
//   spi_clk_i, spi_rst_i   clock shared with the master, async active-high reset
//   cfg_enable_i           allow launches
//   cfg_msb_first_i        bit order latched at launch
//   cfg_div_i              SCK divider code latched at launch
//   cmd_valid_i/ready_o    host command byte in (cmd_data_i)
//   rsp_valid_o/ready_i    received word out (rsp_data_o, rsp_err_o)
//   busy_o                 sequencer active or commands queued
//   txn_count_o            completed transactions (wrapping)
//   m_statusreg_o          master status: [0] op [1] fbo [4:2] div [5] enable
//   m_data_o               master transmit word
//   m_doneflag_i           master done pulse
//   m_data_i               master received word, valid the cycle after done
//
// Build option SPI_SEQ_TIMEOUT_EN: adds a watchdog in WAIT that ends the
// transaction after TIMEOUT_CYC cycles with rsp_data_o all ones and
// rsp_err_o = 1 (not counted in txn_count_o). Without it rsp_err_o is 0 and
// WAIT waits for the done pulse indefinitely.
// -----------------------------------------------------------------------------
module spi_perifericos_seq
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int FIFO_DEPTH  = 4,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                  spi_clk_i,
    input  logic                  spi_rst_i,
    input  logic                  cfg_enable_i,
    input  logic                  cfg_msb_first_i,
    input  logic [2:0]            cfg_div_i,
    input  logic                  cmd_valid_i,
    input  logic [DATA_WIDTH-1:0] cmd_data_i,
    output logic                  cmd_ready_o,
    output logic                  rsp_valid_o,
    output logic [DATA_WIDTH-1:0] rsp_data_o,
    output logic                  rsp_err_o,
    input  logic                  rsp_ready_i,
    output logic                  busy_o,
    output logic [15:0]           txn_count_o,
    output logic [5:0]            m_statusreg_o,
    output logic [DATA_WIDTH-1:0] m_data_o,
    input  logic                  m_doneflag_i,
    input  logic [DATA_WIDTH-1:0] m_data_i
);

    seq_state_e            state_q, state_d;
    logic [5:0]            status_q, status_d;
    logic [DATA_WIDTH-1:0] mdata_q, mdata_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic [15:0]           cnt_q, cnt_d;

    logic                  fifo_push;
    logic                  fifo_pop;
    logic [DATA_WIDTH-1:0] fifo_rd_data;
    logic                  fifo_full;
    logic                  fifo_empty;

`ifdef SPI_SEQ_TIMEOUT_EN
    localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYC - 1);
    localparam logic [DATA_WIDTH-1:0] ALL_ONES = '1;
    logic [15:0] wd_q, wd_d;
    logic        to_q, to_d;     // current transaction ended by the watchdog
    logic        err_q, err_d;
`endif

    assign fifo_push = cmd_valid_i & ~fifo_full;

    spi_seq_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i     (spi_clk_i),
        .rst_i     (spi_rst_i),
        .push_i    (fifo_push),
        .wr_data_i (cmd_data_i),
        .pop_i     (fifo_pop),
        .rd_data_o (fifo_rd_data),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

    always_comb begin
        state_d     = state_q;
        status_d    = status_q;
        mdata_d     = mdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        cnt_d       = cnt_q;
        fifo_pop    = 1'b0;
`ifdef SPI_SEQ_TIMEOUT_EN
        wd_d        = '0;
        to_d        = to_q;
        err_d       = err_q;
`endif
        unique case (state_q)
            IDLE: begin
                // Between transactions the enable bit mirrors the config input.
                status_d[ST_EN] = cfg_enable_i;
                if (!fifo_empty && cfg_enable_i) begin
                    fifo_pop = 1'b1;
                    mdata_d  = fifo_rd_data;
                    status_d = pack_status(1'b1, cfg_div_i, cfg_msb_first_i, 1'b1);
                    state_d  = WAIT;
`ifdef SPI_SEQ_TIMEOUT_EN
                    to_d     = 1'b0;
`endif
                end
            end
            WAIT: begin
`ifdef SPI_SEQ_TIMEOUT_EN
                wd_d = wd_q + 16'd1;
`endif
                // Op drops on the done edge so the master sees it low when it
                // returns to its idle state.
                if (m_doneflag_i) begin
                    status_d[ST_OP] = 1'b0;
                    state_d         = CAPT;
                end
`ifdef SPI_SEQ_TIMEOUT_EN
                else if (wd_q == WD_LAST) begin
                    status_d[ST_OP] = 1'b0;
                    to_d            = 1'b1;
                    state_d         = CAPT;
                end
`endif
            end
            CAPT: begin
                rsp_valid_d = 1'b1;
                state_d     = RESP;
`ifdef SPI_SEQ_TIMEOUT_EN
                if (to_q) begin
                    rsp_data_d = ALL_ONES;
                    err_d      = 1'b1;
                end else begin
                    rsp_data_d = m_data_i;
                    err_d      = 1'b0;
                    cnt_d      = cnt_q + 16'd1;
                end
`else
                rsp_data_d = m_data_i;
                cnt_d      = cnt_q + 16'd1;
`endif
            end
            RESP: begin
                if (rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
`ifdef SPI_SEQ_TIMEOUT_EN
                    err_d       = 1'b0;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge spi_clk_i or posedge spi_rst_i) begin
        if (spi_rst_i) begin
            state_q     <= IDLE;
            status_q    <= '0;
            mdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            cnt_q       <= '0;
`ifdef SPI_SEQ_TIMEOUT_EN
            wd_q        <= '0;
            to_q        <= 1'b0;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            status_q    <= status_d;
            mdata_q     <= mdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            cnt_q       <= cnt_d;
`ifdef SPI_SEQ_TIMEOUT_EN
            wd_q        <= wd_d;
            to_q        <= to_d;
            err_q       <= err_d;
`endif
        end
    end

    assign cmd_ready_o   = ~fifo_full;
    assign rsp_valid_o   = rsp_valid_q;
    assign rsp_data_o    = rsp_data_q;
    assign busy_o        = (state_q != IDLE) | ~fifo_empty;
    assign txn_count_o   = cnt_q;
    assign m_statusreg_o = status_q;
    assign m_data_o      = mdata_q;
`ifdef SPI_SEQ_TIMEOUT_EN
    assign rsp_err_o     = err_q;
`else
    assign rsp_err_o     = 1'b0;
`endif

endmodule

// File: tb/tb_spi_perifericos_seq.sv
module tb_spi_perifericos_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cfg_enable = 1'b0;
    logic       cfg_msb = 1'b0;
    logic [2:0] cfg_div = 3'b000;
    logic       cmd_valid = 1'b0;
    logic [7:0] cmd_data = 8'h00;
    logic       cmd_ready;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       rsp_err;
    logic       rsp_ready = 1'b0;
    logic       busy;
    logic [15:0] txn_count;
    logic [5:0] m_status;
    logic [7:0] m_data;
    logic       m_done = 1'b0;
    logic [7:0] m_rx = 8'h00;

    int checks = 0;
    int failures = 0;
    logic [7:0] exp_q[$];

    spi_perifericos_seq #(
        .DATA_WIDTH  (8),
        .FIFO_DEPTH  (4),
        .TIMEOUT_CYC (16)
    ) dut (
        .spi_clk_i       (clk),
        .spi_rst_i       (rst),
        .cfg_enable_i    (cfg_enable),
        .cfg_msb_first_i (cfg_msb),
        .cfg_div_i       (cfg_div),
        .cmd_valid_i     (cmd_valid),
        .cmd_data_i      (cmd_data),
        .cmd_ready_o     (cmd_ready),
        .rsp_valid_o     (rsp_valid),
        .rsp_data_o      (rsp_data),
        .rsp_err_o       (rsp_err),
        .rsp_ready_i     (rsp_ready),
        .busy_o          (busy),
        .txn_count_o     (txn_count),
        .m_statusreg_o   (m_status),
        .m_data_o        (m_data),
        .m_doneflag_i    (m_done),
        .m_data_i        (m_rx)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Entered at a falling edge; returns at the falling edge after the byte was taken.
    task automatic push_byte(input logic [7:0] d);
        int n;
        cmd_data  = d;
        cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("push_wait", 32'(n), 32'd0);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_launch(input string tag);
        int n;
        n = 0;
        while (!m_status[0] && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(m_status[0]), 32'd1);
    endtask

    // Pulses done, supplies rx, checks the response, optionally stalls rsp_ready.
    task automatic finish_txn(input logic [7:0] rx, input logic [15:0] cnt, input int bp);
        logic [7:0] tx;
        logic [5:0] st;
        tx = m_data;
        m_done = 1'b1;
        @(negedge clk);
        m_done = 1'b0;
        m_rx   = rx;
        chk("op_cleared_on_done", 32'(m_status[0]), 32'd0);
        chk("rsp_not_yet_valid", 32'(rsp_valid), 32'd0);
        st = m_status;
        @(negedge clk);
        m_rx = 8'($urandom_range(0, 255));
        chk("rsp_valid", 32'(rsp_valid), 32'd1);
        chk("rsp_data", 32'(rsp_data), 32'(rx));
        chk("rsp_err", 32'(rsp_err), 32'd0);
        chk("txn_count", 32'(txn_count), 32'(cnt));
        for (int i = 0; i < bp; i++) begin
            @(negedge clk);
            chk("bp_valid_held", 32'(rsp_valid), 32'd1);
            chk("bp_data_held", 32'(rsp_data), 32'(rx));
            chk("bp_status_held", 32'(m_status), 32'(st));
            chk("bp_no_launch", 32'(m_data), 32'(tx));
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("rsp_released", 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_status", 32'(m_status), 32'd0);
        chk("rst_mdata", 32'(m_data), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_count", 32'(txn_count), 32'd0);
        rst = 1'b0;
        cfg_enable = 1'b1;
        cfg_msb    = 1'b1;
        cfg_div    = 3'b000;
        @(negedge clk);

        // Single byte
        push_byte(8'hA5);
        wait_launch("single_launch");
        chk("single_mdata", 32'(m_data), 32'hA5);
        chk("single_status", 32'(m_status), 32'h23);
        chk("single_busy", 32'(busy), 32'd1);
        repeat (3) @(negedge clk);
        chk("single_op_held", 32'(m_status), 32'h23);
        finish_txn(8'h3C, 16'd1, 0);

        // Burst of 6 bytes through a 4-deep FIFO
        cfg_enable = 1'b0;
        @(negedge clk);
        push_byte(8'h11); push_byte(8'h22); push_byte(8'h33); push_byte(8'h44);
        chk("burst_full", 32'(cmd_ready), 32'd0);
        chk("burst_no_launch", 32'(m_status[0]), 32'd0);
        cmd_data   = 8'h55;
        cmd_valid  = 1'b1;
        cfg_enable = 1'b1;
        @(negedge clk);
        chk("burst_first_pop", 32'(m_data), 32'h11);
        chk("burst_ready_after_pop", 32'(cmd_ready), 32'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("burst_full_again", 32'(cmd_ready), 32'd0);
        finish_txn(8'hEE, 16'd2, 0);
        exp_q.push_back(8'h22); exp_q.push_back(8'h33); exp_q.push_back(8'h44);
        exp_q.push_back(8'h55); exp_q.push_back(8'h66);
        push_byte(8'h66);
        for (int k = 0; k < 5; k++) begin
            logic [7:0] e;
            e = exp_q.pop_front();
            wait_launch("burst_launch");
            chk("burst_order", 32'(m_data), 32'(e));
            finish_txn(e ^ 8'hFF, 16'(3 + k), 0);
        end
        chk("burst_idle", 32'(busy), 32'd0);

        // Config latch and response backpressure
        push_byte(8'h77);
        push_byte(8'h88);
        wait_launch("cfg_launch");
        chk("cfg_mdata", 32'(m_data), 32'h77);
        cfg_div = 3'b100;
        cfg_msb = 1'b0;
        repeat (3) @(negedge clk);
        chk("cfg_div_kept", 32'(m_status), 32'h23);
        finish_txn(8'h5A, 16'd8, 20);
        wait_launch("cfg_next_launch");
        chk("cfg_next_mdata", 32'(m_data), 32'h88);
        chk("cfg_next_status", 32'(m_status), 32'h31);
        finish_txn(8'hC3, 16'd9, 0);
        cfg_div = 3'b000;
        cfg_msb = 1'b1;

        // Reset mid-WAIT
        push_byte(8'h99);
        push_byte(8'hAA);
        wait_launch("rst_launch");
        chk("rst_launch_mdata", 32'(m_data), 32'h99);
        rst = 1'b1;
        #1;
        chk("mid_rst_status", 32'(m_status), 32'd0);
        chk("mid_rst_mdata", 32'(m_data), 32'd0);
        chk("mid_rst_rsp_data", 32'(rsp_data), 32'd0);
        chk("mid_rst_count", 32'(txn_count), 32'd0);
        chk("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("post_rst_fifo_empty", 32'(busy), 32'd0);
        chk("post_rst_status", 32'(m_status), 32'h20);

        // Watchdog (or indefinite wait without it)
        push_byte(8'hC3);
        wait_launch("wd_launch");
`ifdef SPI_SEQ_TIMEOUT_EN
        for (int i = 1; i < 16; i++) begin
            @(negedge clk);
            chk("wd_op_held", 32'(m_status[0]), 32'd1);
        end
        @(negedge clk);
        chk("wd_op_cleared", 32'(m_status[0]), 32'd0);
        chk("wd_rsp_pending", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        chk("wd_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("wd_rsp_err", 32'(rsp_err), 32'd1);
        chk("wd_rsp_data", 32'(rsp_data), 32'hFF);
        chk("wd_count", 32'(txn_count), 32'd0);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("wd_released", 32'(rsp_valid), 32'd0);
`else
        repeat (40) @(negedge clk);
        chk("nowd_op_held", 32'(m_status), 32'h23);
        chk("nowd_no_rsp", 32'(rsp_valid), 32'd0);
        finish_txn(8'h5A, 16'd1, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
